// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Arbitrates the single register-file write port between the in-order
//   writeback result and the out-of-order mul/div result. A one-entry buffer
//   absorbs mul/div results while the pipeline owns the port. A bounded-wait
//   counter forces a one-cycle pipeline stall (DRAIN) so a buffered result
//   is never starved.
//
//   Optional feature macro: WB_ARB_BYPASS_EN
//     defined   : a mul/div result arriving in IDLE while the pipeline is not
//                 writing goes straight to the port in the same cycle.
//     undefined : every mul/div result passes through the buffer.
//
// Parameters
//   XLEN      data width
//   MAX_WAIT  cycles a buffered result may wait before a forced drain (>=1)
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   wb_we_W/wb_rd_W/wb_data_W   pipeline writeback request
//   md_valid/md_rd/md_data      mul/div result, held stable until accepted
//   md_ready                    mul/div result accepted on md_valid&&md_ready
//   stall_W                     freeze the pipeline this cycle
//   rf_we/rf_rd/rf_wdata        register-file write port
//   buf_valid/buf_rd/buf_data   pending buffered result (forwarding/scoreboard)

module wb_port_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_we_W,
  input  logic [4:0]      wb_rd_W,
  input  logic [XLEN-1:0] wb_data_W,
  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  output logic            stall_W,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            buf_valid,
  output logic [4:0]      buf_rd,
  output logic [XLEN-1:0] buf_data
);

  localparam int unsigned    CW        = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  logic          buf_load;
  logic          pw, mw;

  // x0 writes from the pipeline are treated as no request at all.
  assign pw       = wb_we_W && (wb_rd_W != '0);
  assign md_ready = !buf_valid;
  assign mw       = md_valid && md_ready;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    buf_load    = 1'b0;
    stall_W     = 1'b0;
    rf_we       = 1'b0;
    rf_rd       = '0;
    rf_wdata    = '0;

    case (state)
      IDLE: begin
        if (pw) begin
          rf_we    = 1'b1;
          rf_rd    = wb_rd_W;
          rf_wdata = wb_data_W;
        end
        // mw with md_rd == 0 is consumed and dropped.
`ifdef WB_ARB_BYPASS_EN
        if (mw && (md_rd != '0)) begin
          if (!pw) begin
            rf_we    = 1'b1;
            rf_rd    = md_rd;
            rf_wdata = md_data;
          end else begin
            buf_load    = 1'b1;
            wait_cnt_nx = '0;
            state_nx    = HOLD;
          end
        end
`else
        if (mw && (md_rd != '0)) begin
          buf_load    = 1'b1;
          wait_cnt_nx = '0;
          state_nx    = HOLD;
        end
`endif
      end

      HOLD: begin
        if (!pw) begin
          rf_we    = 1'b1;
          rf_rd    = buf_rd;
          rf_wdata = buf_data;
          state_nx = IDLE;
        end else begin
          rf_we    = 1'b1;
          rf_rd    = wb_rd_W;
          rf_wdata = wb_data_W;
          if (wb_rd_W == buf_rd) begin
            // Younger pipeline write to the same rd supersedes the buffer.
            state_nx = IDLE;
          end else begin
            wait_cnt_nx = wait_cnt + CW'(1);
            if (wait_cnt == WAIT_LAST) begin
              state_nx = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        // Pipeline write is suppressed; the stalled stage replays it next cycle.
        stall_W  = 1'b1;
        rf_we    = 1'b1;
        rf_rd    = buf_rd;
        rf_wdata = buf_data;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (buf_load) begin
        buf_valid <= 1'b1;
        buf_rd    <= md_rd;
        buf_data  <= md_data;
      end else if (state_nx == IDLE) begin
        buf_valid <= 1'b0;
        buf_rd    <= '0;
        buf_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            wb_we_W;
  logic [4:0]      wb_rd_W;
  logic [XLEN-1:0] wb_data_W;
  logic            md_valid;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_data;
  logic            md_ready;
  logic            stall_W;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            buf_valid;
  logic [4:0]      buf_rd;
  logic [XLEN-1:0] buf_data;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  vectors    = 0;
  int  miscompares = 0;

  wb_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_we_W   (wb_we_W),
    .wb_rd_W   (wb_rd_W),
    .wb_data_W (wb_data_W),
    .md_valid  (md_valid),
    .md_rd     (md_rd),
    .md_data   (md_data),
    .md_ready  (md_ready),
    .stall_W   (stall_W),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .buf_valid (buf_valid),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each cycle's expected write (if any) is pushed when the
  // stimulus is driven; an empty queue means no write is allowed that cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (rf_we !== 1'b1 || rf_rd !== mon_e.rd || rf_wdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL rf_write @%0t: got we=%b rd=%0d data=%h, want we=1 rd=%0d data=%h",
                   $time, rf_we, rf_rd, rf_wdata, mon_e.rd, mon_e.data);
        end
      end else if (rf_we !== 1'b0) begin
        miscompares++;
        $display("FAIL unexpected_write @%0t: got we=%b rd=%0d data=%h, want we=0",
                 $time, rf_we, rf_rd, rf_wdata);
      end
    end
  end

  task automatic push_wr(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    md_valid = 1'b1;
    md_rd    = 5'd5;
    md_data  = 32'h1234_5678;
    #3;
    vectors++; if (rf_we !== 1'b0)    begin miscompares++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    vectors++; if (stall_W !== 1'b0)  begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_W); end
    vectors++; if (md_ready !== 1'b1) begin miscompares++; $display("FAIL reset_md_ready: got %b want 1", md_ready); end
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL reset_buf_valid: got %b want 0", buf_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL release_rf_we: got %b want 0", rf_we); end
  endtask

  // md_valid (rd=5) is already pending from test_reset.
  task automatic test_md_buffered();
    @(posedge clk); #1;
    md_valid = 1'b0;
    push_wr(5'd5, 32'h1234_5678);
    vectors++; if (buf_valid !== 1'b1) begin miscompares++; $display("FAIL buf_load_valid: got %b want 1", buf_valid); end
    vectors++; if (buf_rd !== 5'd5)    begin miscompares++; $display("FAIL buf_load_rd: got %0d want 5", buf_rd); end
    vectors++; if (buf_data !== 32'h1234_5678) begin miscompares++; $display("FAIL buf_load_data: got %h want 12345678", buf_data); end
    vectors++; if (md_ready !== 1'b0)  begin miscompares++; $display("FAIL hold_md_ready: got %b want 0", md_ready); end
    @(posedge clk); #1;
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL buf_cleared: got %b want 0", buf_valid); end
    vectors++; if (md_ready !== 1'b1)  begin miscompares++; $display("FAIL md_ready_back: got %b want 1", md_ready); end
  endtask

  task automatic test_drain();
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h0000_7777;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      md_valid  = 1'b0;
      wb_we_W   = 1'b1;
      wb_rd_W   = 5'd3;
      wb_data_W = 32'h3000 + 32'(i);
      push_wr(5'd3, wb_data_W);
      @(negedge clk);
      vectors++; if (stall_W !== 1'b0) begin miscompares++; $display("FAIL hold_stall[%0d]: got %b want 0", i, stall_W); end
    end
    @(posedge clk); #1;
    wb_data_W = 32'h3004;
    push_wr(5'd7, 32'h0000_7777);
    @(negedge clk);
    vectors++; if (stall_W !== 1'b1) begin miscompares++; $display("FAIL drain_stall: got %b want 1", stall_W); end
    vectors++; if (md_ready !== 1'b0) begin miscompares++; $display("FAIL drain_md_ready: got %b want 0", md_ready); end
    @(posedge clk); #1;
    push_wr(5'd3, 32'h3004);
    @(negedge clk);
    vectors++; if (stall_W !== 1'b0)   begin miscompares++; $display("FAIL retry_stall: got %b want 0", stall_W); end
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL retry_buf_valid: got %b want 0", buf_valid); end
    @(posedge clk); #1;
    wb_we_W = 1'b0;
  endtask

  task automatic test_kill();
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h0000_AAAA;
    @(posedge clk); #1;
    md_valid  = 1'b0;
    wb_we_W   = 1'b1;
    wb_rd_W   = 5'd9;
    wb_data_W = 32'h0000_BBBB;
    push_wr(5'd9, 32'h0000_BBBB);
    @(negedge clk);
    vectors++; if (rf_wdata !== 32'h0000_BBBB) begin miscompares++; $display("FAIL kill_wdata: got %h want 0000bbbb", rf_wdata); end
    @(posedge clk); #1;
    wb_we_W = 1'b0;
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL kill_buf_valid: got %b want 0", buf_valid); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_hold_release();
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'h0000_C0C0;
    @(posedge clk); #1;
    md_valid  = 1'b0;
    wb_we_W   = 1'b1;
    wb_rd_W   = 5'd4;
    wb_data_W = 32'h0000_4444;
    push_wr(5'd4, 32'h0000_4444);
    @(posedge clk); #1;
    wb_we_W = 1'b0;
    push_wr(5'd12, 32'h0000_C0C0);
    vectors++; if (buf_valid !== 1'b1) begin miscompares++; $display("FAIL release_buf_still: got %b want 1", buf_valid); end
    @(posedge clk); #1;
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL release_buf_clear: got %b want 0", buf_valid); end
  endtask

  task automatic test_x0();
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0000_DEAD;
    wb_we_W  = 1'b1; wb_rd_W = 5'd0; wb_data_W = 32'h0000_0BAD;
    #1;
    vectors++; if (md_ready !== 1'b1) begin miscompares++; $display("FAIL x0_md_ready: got %b want 1", md_ready); end
    vectors++; if (rf_we !== 1'b0)    begin miscompares++; $display("FAIL x0_rf_we: got %b want 0", rf_we); end
    @(posedge clk); #1;
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL x0_buf_valid: got %b want 0", buf_valid); end
    md_valid = 1'b0;
    wb_we_W  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_hold();
    md_valid = 1'b1; md_rd = 5'd11; md_data = 32'h0000_BEEF;
    @(posedge clk); #1;
    md_valid = 1'b0;
    vectors++; if (buf_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_loaded: got %b want 1", buf_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (buf_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_buf_valid: got %b want 0", buf_valid); end
    vectors++; if (md_ready !== 1'b1)  begin miscompares++; $display("FAIL midrst_md_ready: got %b want 1", md_ready); end
    vectors++; if (buf_rd !== 5'd0)    begin miscompares++; $display("FAIL midrst_buf_rd: got %0d want 0", buf_rd); end
    vectors++; if (rf_we !== 1'b0)     begin miscompares++; $display("FAIL midrst_rf_we: got %b want 0", rf_we); end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    wb_we_W   = 1'b0;
    wb_rd_W   = '0;
    wb_data_W = '0;
    md_valid  = 1'b0;
    md_rd     = '0;
    md_data   = '0;

    test_reset();
    test_md_buffered();
    test_drain();
    test_kill();
    test_hold_release();
    test_x0();
    test_reset_mid_hold();

    @(negedge clk); #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drained: got %0d pending writes, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order writeback result (output of the writeback result mux) and the out-of-order result of the iterative multiply/divide unit. A one-entry holding buffer absorbs mul/div results while the pipeline owns the port. A bounded-wait counter forces a one-cycle pipeline stall so that a buffered result can never starve. Sits between the WB stage, the mul/div unit and the register file.

## Interface
Parameters:
- XLEN, 32, data width
- MAX_WAIT, 4, cycles a buffered result may wait before a forced drain (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_we_W  in  1  pipeline writeback request
- wb_rd_W  in  5  pipeline destination register
- wb_data_W  in  XLEN  pipeline write data (reg_write_data_W)
- md_valid  in  1  mul/div result valid
- md_rd  in  5  mul/div destination register
- md_data  in  XLEN  mul/div result
- md_ready  out  1  result accepted when md_valid && md_ready
- stall_W  out  1  freeze the pipeline this cycle
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- buf_valid  out  1  buffer holds a pending result (for forwarding/scoreboard)
- buf_rd  out  5  buffered destination
- buf_data  out  XLEN  buffered data

## Operation
- Definitions:
  - pw = wb_we_W && wb_rd_W != 0
  - mw = md_valid && md_ready
- md_ready = !buf_valid, combinational.
- States:
  - IDLE: buffer empty. If pw, the port carries the pipeline write. On mw with md_rd != 0, md_rd/md_data are loaded into the buffer and the state becomes HOLD with wait_cnt = 0. On mw with md_rd == 0, the result is consumed and discarded.
  - HOLD: buffer full. Exactly one of the following applies, in priority order:
    - !pw: the port writes the buffer; buffer clears; go to IDLE.
    - pw && wb_rd_W == buf_rd: the younger pipeline write wins; the buffer is killed (no write); go to IDLE.
    - Otherwise: the pipeline write proceeds and wait_cnt increments. When wait_cnt == MAX_WAIT-1 at the edge, go to DRAIN instead.
  - DRAIN: stall_W = 1; the port writes the buffer; the pipeline write is suppressed (the pipeline retries it next cycle); go to IDLE.
- stall_W is asserted only in DRAIN.
- rf_we = 0 whenever neither source is selected.
- x0 is never written by either source.

## Timing
- Reset values:
  - state IDLE
  - buf_valid 0, buf_rd 0, buf_data 0, wait_cnt 0
  - rf_we 0, stall_W 0, md_ready 1
- rf_* and stall_W are combinational from state, the buffer and the current inputs. Register-file write occurs at the next rising edge.
- A buffered result is written at the earliest 1 cycle after acceptance, and at the latest MAX_WAIT+1 cycles after.
- The mul/div unit must hold md_valid/md_rd/md_data stable until accepted.
- No acceptance occurs in the cycle the buffer drains; md_ready rises the cycle after.
- Reset mid-operation discards any buffered result and returns the block to IDLE immediately (asynchronously).
- wait_cnt width is clog2(MAX_WAIT)+1 bits; it is cleared on every entry to HOLD.

## Configuration
- WB_ARB_BYPASS_EN defined:
  - Applies in IDLE when mw && md_rd != 0 && !pw.
  - The result is written through the port in the same cycle (rf_rd = md_rd, rf_wdata = md_data).
  - The buffer is not loaded and the state stays IDLE.
- WB_ARB_BYPASS_EN undefined: every mul/div result passes through the buffer (minimum latency of 1 cycle).

## Test plan
- Reset with md_valid=1: rf_we=0, stall_W=0, md_ready=1. Release reset: no register write occurs until the next edge decision.
- Idle pipeline, md_valid with rd=5, data=0x1234_5678:
  - Bypass off: buffered, then rf_we=1, rf_rd=5, rf_wdata=0x12345678 exactly one cycle later.
  - Bypass on: rf write occurs in the same cycle.
- Buffered rd=7; pipeline writes rd=3 in 4 consecutive cycles (MAX_WAIT=4): stall_W=1 in cycle 5, with rf_rd=7. The pipeline's rd=3 write is suppressed that cycle and lands in cycle 6.
- Buffered rd=9 with data 0xAAAA; pipeline writes rd=9 with data 0xBBBB: rf_wdata=0xBBBB, buf_valid falls, and 0xAAAA is never written.
- md result with rd=0: md_ready=1 and the result is consumed; rf_we stays 0 and buf_valid stays 0.
- Buffer full, rst_n asserted low mid-HOLD: buf_valid=0 and state IDLE immediately, with no rf write afterward.
